// File: rtl/transport_ctrl.sv
// transport_ctrl
// Top-level transport state machine for the audio recorder. It owns the
// play/record/pause/stop state, the playback speed setting, the sample
// address pointer and the recorded length, and paces everything from the
// per-sample tick supplied by the I2S/DSP path.
//
// Optional feature (compile-time macro LOOP_PLAY_EN):
//   defined   -> playback wraps around at the end of the recording,
//                with end_o still pulsing once per wrap.
//   undefined -> playback stops automatically at the end of the recording.
//
// Speed model: exactly one of spd_mul_o / spd_div_o may exceed 1. Fast
// playback skips samples (addr += spd_mul). Slow playback holds each sample
// for spd_div ticks using a small sub-counter.
module transport_ctrl #(
  parameter int ADDR_W   = 20,
  parameter int MAX_UP   = 8,
  parameter int MAX_DOWN = 8,
  parameter int SPD_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              mode,
  input  logic              btn_play,
  input  logic              btn_stop,
  input  logic              btn_fast,
  input  logic              btn_slow,
  input  logic              sample_tick,
  output logic [2:0]        state_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] rec_len_o,
  output logic [SPD_W-1:0]  spd_mul_o,
  output logic [SPD_W-1:0]  spd_div_o,
  output logic              active_o,
  output logic              end_o
);

  // Bit 2 of every encoding is the mode bit (0 = play, 1 = record).
  // INIT carries a 1 there so speed is held at normal until configured.
  typedef enum logic [2:0] {
    S_PLAY_STOP  = 3'b000,
    S_PLAY       = 3'b010,
    S_PLAY_PAUSE = 3'b011,
    S_REC_STOP   = 3'b100,
    S_INIT       = 3'b101,
    S_REC        = 3'b110,
    S_REC_PAUSE  = 3'b111
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [SPD_W-1:0]  SPD_ONE   = SPD_W'(1);
  localparam logic [SPD_W-1:0]  UP_LIM    = SPD_W'(MAX_UP);
  localparam logic [SPD_W-1:0]  DOWN_LIM  = SPD_W'(MAX_DOWN);

  state_t             state;
  logic [SPD_W-1:0]   sub_cnt;

  // Speed-step helpers
  logic               speed_req;
  logic [SPD_W-1:0]   mul_nxt;
  logic [SPD_W-1:0]   div_nxt;

  // Playback-advance helpers
  logic               slow_mode;
  logic               sub_wrap;
  logic               play_step;
  logic               play_end;
  logic [ADDR_W:0]    play_inc;
  logic [ADDR_W:0]    play_sum;
  logic [ADDR_W:0]    len_ext;
`ifdef LOOP_PLAY_EN
  logic [ADDR_W-1:0]  loop_addr;
`endif

  // Record-advance helpers
  logic               rec_full;
  logic [ADDR_W-1:0]  addr_inc;

  assign state_o = state;

  // Active exactly in PLAY (010) and REC (110); decoded straight from the
  // state register, so it carries the same one-cycle latency as state_o.
  assign active_o = state[1] & ~state[0];

  // Next speed setting for a single fast or slow press. Pressing both at
  // once cancels out, and record mode (state bit 2) ignores the buttons.
  always_comb begin
    speed_req = ~state[2] & (btn_fast ^ btn_slow);
    mul_nxt   = spd_mul_o;
    div_nxt   = spd_div_o;
    if (btn_fast) begin
      if (spd_div_o > SPD_ONE)
        div_nxt = spd_div_o - SPD_ONE;
      else if (spd_mul_o < UP_LIM)
        mul_nxt = spd_mul_o + SPD_ONE;
    end else begin
      if (spd_mul_o > SPD_ONE)
        mul_nxt = spd_mul_o - SPD_ONE;
      else if (spd_div_o < DOWN_LIM)
        div_nxt = spd_div_o + SPD_ONE;
    end
  end

  // Candidate playback address for this tick, computed one bit wider than
  // the address so the end-of-data compare cannot be fooled by wraparound.
  always_comb begin
    slow_mode = spd_div_o > SPD_ONE;
    sub_wrap  = sub_cnt == (spd_div_o - SPD_ONE);
    play_step = ~slow_mode | sub_wrap;
    play_inc  = slow_mode ? (ADDR_W+1)'(1) : (ADDR_W+1)'(spd_mul_o);
    play_sum  = {1'b0, addr_o} + play_inc;
    len_ext   = {1'b0, rec_len_o};
    play_end  = (rec_len_o == '0) | (play_step & (play_sum >= len_ext));
`ifdef LOOP_PLAY_EN
    loop_addr = ADDR_W'(play_sum - len_ext);
`endif
    rec_full  = addr_o == ADDR_LAST;
    addr_inc  = addr_o + ADDR_W'(1);
  end

  // Transport FSM with the address, recorded length, speed and end pulse
  // all held in registers updated together on each clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      addr_o    <= '0;
      rec_len_o <= '0;
      spd_mul_o <= SPD_ONE;
      spd_div_o <= SPD_ONE;
      sub_cnt   <= '0;
      end_o     <= 1'b0;
    end else begin
      end_o <= 1'b0;

      if (state[2]) begin
        spd_mul_o <= SPD_ONE;
        spd_div_o <= SPD_ONE;
      end else if (speed_req) begin
        spd_mul_o <= mul_nxt;
        spd_div_o <= div_nxt;
      end

      case (state)
        S_INIT: begin
          if (init_done)
            state <= mode ? S_REC_STOP : S_PLAY_STOP;
        end

        S_PLAY_STOP, S_REC_STOP: begin
          if (mode != state[2]) begin
            state  <= mode ? S_REC_STOP : S_PLAY_STOP;
            addr_o <= '0;
          end else if (btn_play && !btn_stop) begin
            state  <= mode ? S_REC : S_PLAY;
            addr_o <= '0;
            if (mode)
              rec_len_o <= '0;
          end
        end

        S_PLAY: begin
          if (btn_stop) begin
            state   <= S_PLAY_STOP;
            addr_o  <= '0;
            sub_cnt <= '0;
          end else if (btn_play) begin
            state <= S_PLAY_PAUSE;
          end else if (sample_tick) begin
            if (slow_mode)
              sub_cnt <= sub_wrap ? '0 : sub_cnt + SPD_ONE;
            if (play_end) begin
              end_o <= 1'b1;
`ifdef LOOP_PLAY_EN
              if (rec_len_o == '0) begin
                state   <= S_PLAY_STOP;
                addr_o  <= '0;
                sub_cnt <= '0;
              end else begin
                addr_o <= loop_addr;
              end
`else
              state   <= S_PLAY_STOP;
              addr_o  <= '0;
              sub_cnt <= '0;
`endif
            end else if (play_step) begin
              addr_o <= play_sum[ADDR_W-1:0];
            end
          end
        end

        S_REC: begin
          if (btn_stop) begin
            state  <= S_REC_STOP;
            addr_o <= '0;
          end else if (btn_play) begin
            state <= S_REC_PAUSE;
          end else if (sample_tick) begin
            if (rec_full) begin
              rec_len_o <= ADDR_LAST;
              state     <= S_REC_STOP;
              addr_o    <= '0;
              end_o     <= 1'b1;
            end else begin
              addr_o    <= addr_inc;
              rec_len_o <= addr_inc;
            end
          end
        end

        S_PLAY_PAUSE, S_REC_PAUSE: begin
          if (mode != state[2]) begin
            state   <= mode ? S_REC_STOP : S_PLAY_STOP;
            addr_o  <= '0;
            sub_cnt <= '0;
          end else if (btn_stop) begin
            state   <= state[2] ? S_REC_STOP : S_PLAY_STOP;
            addr_o  <= '0;
            sub_cnt <= '0;
          end else if (btn_play) begin
            state <= state[2] ? S_REC : S_PLAY;
          end
        end

        default: begin
          state <= S_INIT;
        end
      endcase

      // A speed change restarts the slow-play hold so the new divisor
      // takes effect from a clean sample boundary.
      if (speed_req)
        sub_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_transport_ctrl.sv
// tb_transport_ctrl
// Directed scenarios followed by a randomized run, all compared against a
// behavioural model that tracks mode, phase (stopped/running/paused),
// address, recorded length and speed as plain integers.
module tb_transport_ctrl;

  localparam int AW    = 4;
  localparam int SW    = 4;
  localparam int MU    = 8;
  localparam int MD    = 8;
  localparam int DEPTH = 1 << AW;

  localparam int PH_STOP  = 0;
  localparam int PH_RUN   = 1;
  localparam int PH_PAUSE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_done;
  logic          mode;
  logic          btn_play;
  logic          btn_stop;
  logic          btn_fast;
  logic          btn_slow;
  logic          sample_tick;
  logic [2:0]    state_o;
  logic [AW-1:0] addr_o;
  logic [AW-1:0] rec_len_o;
  logic [SW-1:0] spd_mul_o;
  logic [SW-1:0] spd_div_o;
  logic          active_o;
  logic          end_o;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit m_init;
  bit m_mode;
  int m_phase;
  int m_addr;
  int m_len;
  int m_mul;
  int m_div;
  int m_sub;
  bit m_end;

  transport_ctrl #(
    .ADDR_W  (AW),
    .MAX_UP  (MU),
    .MAX_DOWN(MD),
    .SPD_W   (SW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .init_done  (init_done),
    .mode       (mode),
    .btn_play   (btn_play),
    .btn_stop   (btn_stop),
    .btn_fast   (btn_fast),
    .btn_slow   (btn_slow),
    .sample_tick(sample_tick),
    .state_o    (state_o),
    .addr_o     (addr_o),
    .rec_len_o  (rec_len_o),
    .spd_mul_o  (spd_mul_o),
    .spd_div_o  (spd_div_o),
    .active_o   (active_o),
    .end_o      (end_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired got=timeout want=finish");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [2:0] exp_state();
    if (m_init) return 3'b101;
    case (m_phase)
      PH_STOP: return {m_mode, 2'b00};
      PH_RUN:  return {m_mode, 2'b10};
      default: return {m_mode, 2'b11};
    endcase
  endfunction

  task automatic model_stop();
    m_phase = PH_STOP;
    m_addr  = 0;
    m_sub   = 0;
  endtask

  // One clock of the reference behaviour, driven by the current inputs.
  task automatic model_step();
    int  mul0 = m_mul;
    int  div0 = m_div;
    bit  chg  = 0;
    bit  stepped;
    int  res;
    m_end = 0;
    if (rst) begin
      m_init = 1; m_mode = 1; m_phase = PH_STOP;
      m_addr = 0; m_len = 0; m_mul = 1; m_div = 1; m_sub = 0;
      return;
    end
    if (m_init || m_mode) begin
      m_mul = 1; m_div = 1;
    end else if (btn_fast != btn_slow) begin
      chg = 1;
      if (btn_fast) begin
        if (div0 > 1) m_div = div0 - 1; else if (mul0 < MU) m_mul = mul0 + 1;
      end else begin
        if (mul0 > 1) m_mul = mul0 - 1; else if (div0 < MD) m_div = div0 + 1;
      end
    end
    if (m_init) begin
      if (init_done) begin
        m_init = 0; m_mode = mode; m_phase = PH_STOP; m_addr = 0;
      end
    end else begin
      case (m_phase)
        PH_STOP: begin
          if (mode != m_mode) m_mode = mode;
          else if (btn_play && !btn_stop) begin
            m_phase = PH_RUN; m_addr = 0;
            if (m_mode) m_len = 0;
          end
        end
        PH_RUN: begin
          if (btn_stop) model_stop();
          else if (btn_play) m_phase = PH_PAUSE;
          else if (sample_tick) begin
            if (m_mode) begin
              if (m_addr == DEPTH - 1) begin
                m_len = DEPTH - 1; model_stop(); m_end = 1;
              end else begin
                m_addr = m_addr + 1; m_len = m_addr;
              end
            end else begin
              stepped = 0; res = m_addr;
              if (div0 > 1) begin
                if (m_sub == div0 - 1) begin m_sub = 0; stepped = 1; res = m_addr + 1; end
                else m_sub = m_sub + 1;
              end else begin
                stepped = 1; res = m_addr + mul0;
              end
              if (m_len == 0) begin
                model_stop(); m_end = 1;
              end else if (stepped && res >= m_len) begin
                m_end = 1;
`ifdef LOOP_PLAY_EN
                m_addr = res - m_len;
`else
                model_stop();
`endif
              end else begin
                m_addr = res;
              end
            end
          end
        end
        default: begin
          if (mode != m_mode) begin m_mode = mode; model_stop(); end
          else if (btn_stop) model_stop();
          else if (btn_play) m_phase = PH_RUN;
        end
      endcase
    end
    if (chg) m_sub = 0;
  endtask

  // Apply one cycle of button/tick pulses; level inputs are set by callers.
  task automatic drive(input bit p, input bit s, input bit f, input bit sl, input bit t);
    @(negedge clk);
    btn_play = p; btn_stop = s; btn_fast = f; btn_slow = sl; sample_tick = t;
    model_step();
    @(posedge clk);
    #1;
    btn_play = 0; btn_stop = 0; btn_fast = 0; btn_slow = 0; sample_tick = 0;
  endtask

  task automatic test_reset();
    rst = 1; init_done = 1; mode = 1;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    checks++;
    if (state_o !== 3'b101) begin failures++; $display("[TB] FAIL reset_state got=%b want=101", state_o); end
    checks++;
    if ({addr_o, rec_len_o} !== '0) begin failures++; $display("[TB] FAIL reset_addr_len got=%0d/%0d want=0/0", addr_o, rec_len_o); end
    checks++;
    if (spd_mul_o !== 4'd1 || spd_div_o !== 4'd1) begin failures++; $display("[TB] FAIL reset_speed got=%0d/%0d want=1/1", spd_mul_o, spd_div_o); end
    checks++;
    if (active_o !== 1'b0 || end_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_flags got=%b%b want=00", active_o, end_o); end
    rst = 0;
    drive(0, 0, 0, 0, 0);
    checks++;
    if (state_o !== 3'b100) begin failures++; $display("[TB] FAIL init_to_rec_stop got=%b want=100", state_o); end
  endtask

  task automatic test_record();
    drive(1, 0, 0, 0, 0);
    checks++;
    if (state_o !== 3'b110 || active_o !== 1'b1) begin failures++; $display("[TB] FAIL rec_enter got=%b/%b want=110/1", state_o, active_o); end
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1);
    checks++;
    if (addr_o !== 4'd5 || rec_len_o !== 4'd5) begin failures++; $display("[TB] FAIL rec_5_ticks got=%0d/%0d want=5/5", addr_o, rec_len_o); end
    drive(0, 1, 0, 0, 0);
    checks++;
    if (state_o !== 3'b100 || rec_len_o !== 4'd5 || addr_o !== 4'd0) begin
      failures++; $display("[TB] FAIL rec_stop got=%b len=%0d addr=%0d want=100 len=5 addr=0", state_o, rec_len_o, addr_o);
    end
  endtask

  task automatic test_fast_play();
    mode = 0;
    drive(0, 0, 0, 0, 0);
    checks++;
    if (state_o !== 3'b000) begin failures++; $display("[TB] FAIL mode_switch got=%b want=000", state_o); end
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 0, 0);
    checks++;
    if (spd_mul_o !== 4'd4 || spd_div_o !== 4'd1) begin failures++; $display("[TB] FAIL fast_x3 got=%0d/%0d want=4/1", spd_mul_o, spd_div_o); end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (addr_o !== 4'd4 || end_o !== 1'b0) begin failures++; $display("[TB] FAIL fast_tick1 got=%0d/%b want=4/0", addr_o, end_o); end
    drive(0, 0, 0, 0, 1);
`ifdef LOOP_PLAY_EN
    checks++;
    if (end_o !== 1'b1 || state_o !== 3'b010 || addr_o !== 4'd3) begin
      failures++; $display("[TB] FAIL play_wrap got=%b/%b/%0d want=1/010/3", end_o, state_o, addr_o);
    end
`else
    checks++;
    if (end_o !== 1'b1 || state_o !== 3'b000 || addr_o !== 4'd0) begin
      failures++; $display("[TB] FAIL play_end got=%b/%b/%0d want=1/000/0", end_o, state_o, addr_o);
    end
`endif
    drive(0, 0, 0, 0, 0);
    checks++;
    if (end_o !== 1'b0) begin failures++; $display("[TB] FAIL end_single_pulse got=%b want=0", end_o); end
  endtask

  task automatic test_slow_play();
    int exp_a[6] = '{0, 0, 1, 1, 1, 2};
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0);
    checks++;
    if (spd_mul_o !== 4'd1 || spd_div_o !== 4'd1) begin failures++; $display("[TB] FAIL slow_to_normal got=%0d/%0d want=1/1", spd_mul_o, spd_div_o); end
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    checks++;
    if (spd_div_o !== 4'd3) begin failures++; $display("[TB] FAIL slow_x2 got=%0d want=3", spd_div_o); end
    drive(0, 0, 1, 1, 0);
    checks++;
    if (spd_div_o !== 4'd3 || spd_mul_o !== 4'd1) begin failures++; $display("[TB] FAIL fast_slow_cancel got=%0d/%0d want=1/3", spd_mul_o, spd_div_o); end
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 1);
      checks++;
      if (addr_o !== 4'(exp_a[i])) begin failures++; $display("[TB] FAIL slow_tick%0d got=%0d want=%0d", i + 1, addr_o, exp_a[i]); end
    end
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 0, 0);
    checks++;
    if (spd_div_o !== 4'd1 || spd_mul_o !== 4'd8) begin failures++; $display("[TB] FAIL fast_saturate got=%0d/%0d want=8/1", spd_mul_o, spd_div_o); end
  endtask

  task automatic test_mem_full();
    int ends = 0;
    drive(0, 1, 0, 0, 0);
    mode = 1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (spd_mul_o !== 4'd1 || spd_div_o !== 4'd1) begin failures++; $display("[TB] FAIL rec_speed_forced got=%0d/%0d want=1/1", spd_mul_o, spd_div_o); end
    for (int i = 0; i < DEPTH - 1; i++) begin
      drive(0, 0, 0, 0, 1);
      if (end_o) ends++;
    end
    checks++;
    if (ends != 0 || addr_o !== 4'd15) begin failures++; $display("[TB] FAIL full_early_end got=%0d/%0d want=0/15", ends, addr_o); end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (end_o !== 1'b1 || state_o !== 3'b100 || rec_len_o !== 4'd15 || addr_o !== 4'd0) begin
      failures++; $display("[TB] FAIL full_stop got=%b/%b/%0d/%0d want=1/100/15/0", end_o, state_o, rec_len_o, addr_o);
    end
  endtask

  task automatic test_priority();
    mode = 0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (state_o !== 3'b011 || addr_o !== 4'd3) begin failures++; $display("[TB] FAIL pause_hold got=%b/%0d want=011/3", state_o, addr_o); end
    drive(0, 0, 0, 0, 1);
    checks++;
    if (addr_o !== 4'd3) begin failures++; $display("[TB] FAIL pause_tick got=%0d want=3", addr_o); end
    mode = 1;
    drive(0, 1, 0, 0, 0);
    checks++;
    if (state_o !== 3'b100 || addr_o !== 4'd0) begin failures++; $display("[TB] FAIL pause_mode_stop got=%b/%0d want=100/0", state_o, addr_o); end
    mode = 0;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    checks++;
    if (state_o !== 3'b000) begin failures++; $display("[TB] FAIL stop_beats_play got=%b want=000", state_o); end
    mode = 1;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    rst = 1;
    drive(0, 0, 0, 0, 0);
    rst = 0;
    checks++;
    if (state_o !== 3'b101 || rec_len_o !== 4'd0 || addr_o !== 4'd0) begin
      failures++; $display("[TB] FAIL mid_rec_reset got=%b/%0d/%0d want=101/0/0", state_o, rec_len_o, addr_o);
    end
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    logic [20:0] got;
    logic [20:0] want;
    for (int i = 0; i < 1500; i++) begin
      int r;
      bit p, s, f, sl, t;
      r = int'($urandom_range(0, 199));
      p = 0; s = 0; f = 0; sl = 0; t = 0;
      if (r < 100) t = 1;
      else if (r < 120) p = 1;
      else if (r < 128) s = 1;
      else if (r < 145) f = 1;
      else if (r < 162) sl = 1;
      else if (r < 170) mode = ~mode;
      else if (r < 174) begin p = 1; s = 1; end
      else if (r < 178) begin f = 1; sl = 1; end
      else if (r < 180) rst = 1;
      drive(p, s, f, sl, t);
      rst = 0;
      got  = {state_o, addr_o, rec_len_o, spd_mul_o, spd_div_o, active_o, end_o};
      want = {exp_state(), AW'(m_addr), AW'(m_len), SW'(m_mul), SW'(m_div),
              (m_phase == PH_RUN && !m_init), m_end};
      checks++;
      if (got !== want) begin
        failures++;
        $display("[TB] FAIL random_cycle%0d got=%h want=%h (state/addr/len/mul/div/act/end)", i, got, want);
      end
    end
  endtask

  initial begin
    rst = 1; init_done = 0; mode = 1;
    btn_play = 0; btn_stop = 0; btn_fast = 0; btn_slow = 0; sample_tick = 0;
    test_reset();
    test_record();
    test_fast_play();
    test_slow_play();
    test_mem_full();
    test_priority();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
